lcd_hd44780_init_writer: RTL and testbench

// - Tiny Tapeout top (tt_um_lcd_controller_Andres078). Drives an HD44780 character LCD in 4-bit mode.
// - After reset: forced init, configuration commands, then writes the fixed message "THE GAME  " (10 chars).
// - Then idles until the next reset. Every byte goes out as two nibbles, high nibble first, each latched by an EN pulse.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_delay_timer.sv | 34 +++
 rtl/lcd_hd44780_init_writer.sv | 163 ++++++++++++++++
 tb/tb_lcd_hd44780_init_writer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and delay helper for the HD44780 4-bit init/message writer.
package lcd_pkg;

  localparam logic [7:0] FUNC_8B    = 8'h30;
  localparam logic [7:0] FUNC_4B    = 8'h20;
  localparam logic [7:0] FUNC_4B_2L = 8'h28;
  localparam logic [7:0] DISP_OFF   = 8'h08;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY_INC  = 8'h06;
  localparam logic [7:0] DISP_ON    = 8'h0C;

  localparam int unsigned NUM_CMD   = 9;
  localparam int unsigned MSG_LEN   = 10;
  localparam int unsigned NUM_BYTES = NUM_CMD + MSG_LEN;

  localparam int unsigned TMR_W = 20;

  typedef enum logic [2:0] {
    StPwrup,
    StLoad,
    StEnHi1,
    StGap1,
    StLoad2,
    StEnHi2,
    StWait,
    StDone
  } lcd_state_e;

  // Down-counter load value for a wait of `us` microseconds.
  function automatic logic [TMR_W-1:0] us_to_load(input int unsigned us,
                                                  input int unsigned clk_hz);
    return TMR_W'(us * (clk_hz / 1_000_000) - 1);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done while the count sits at zero.
module lcd_delay_timer #(
  parameter int unsigned     Width  = 20,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= RstVal;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/lcd_hd44780_init_writer.sv
// HD44780 4-bit mode driver: power-up wait, init/config commands, then the fixed message, then idle.
module lcd_hd44780_init_writer
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned T_PWRUP_US = 15000,
  parameter int unsigned T_CMD_US   = 50,
  parameter int unsigned T_INIT1_US = 5000,
  parameter int unsigned T_INIT2_US = 200,
  parameter int unsigned T_CLR_US   = 2000,
  parameter int unsigned T_NIB_US   = 1,
  parameter int unsigned EN_CYC     = 12
) (
  input  logic       clk,
  input  logic       rst_n,  // active-high asynchronous reset despite the name
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [TMR_W-1:0] LdPwrup = us_to_load(T_PWRUP_US, CLK_HZ);
  localparam logic [TMR_W-1:0] LdCmd   = us_to_load(T_CMD_US, CLK_HZ);
  localparam logic [TMR_W-1:0] LdInit1 = us_to_load(T_INIT1_US, CLK_HZ);
  localparam logic [TMR_W-1:0] LdInit2 = us_to_load(T_INIT2_US, CLK_HZ);
  localparam logic [TMR_W-1:0] LdClr   = us_to_load(T_CLR_US, CLK_HZ);
  localparam logic [TMR_W-1:0] LdNib   = us_to_load(T_NIB_US, CLK_HZ);
  localparam logic [TMR_W-1:0] LdSetup = TMR_W'(1);
  localparam logic [TMR_W-1:0] LdEn    = TMR_W'(EN_CYC - 1);
  localparam logic [4:0]       LastIdx = 5'(NUM_BYTES - 1);
  localparam logic [4:0]       FirstData = 5'(NUM_CMD);

  lcd_state_e       state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [7:0]       cur_byte;
  logic [TMR_W-1:0] gap_ld, tmr_val;
  logic             tmr_load, tmr_done;
  logic             en, rs;
  logic             unused_inputs;

  assign unused_inputs = ^{ena, ui_in, uio_in};

  lcd_delay_timer #(
    .Width  (TMR_W),
    .RstVal (LdPwrup)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    case (idx_q)
      5'd0, 5'd1, 5'd2: cur_byte = FUNC_8B;
      5'd3:             cur_byte = FUNC_4B;
      5'd4:             cur_byte = FUNC_4B_2L;
      5'd5:             cur_byte = DISP_OFF;
      5'd6:             cur_byte = CLEAR;
      5'd7:             cur_byte = ENTRY_INC;
      5'd8:             cur_byte = DISP_ON;
      5'd9:             cur_byte = "T";
      5'd10:            cur_byte = "H";
      5'd11:            cur_byte = "E";
      5'd12:            cur_byte = " ";
      5'd13:            cur_byte = "G";
      5'd14:            cur_byte = "A";
      5'd15:            cur_byte = "M";
      5'd16:            cur_byte = "E";
      default:          cur_byte = " ";
    endcase
  end

  // Post-byte gap: the first two 0x30s and CLEAR need longer settling than ordinary commands.
  always_comb begin
    case (idx_q)
      5'd0:    gap_ld = LdInit1;
      5'd1:    gap_ld = LdInit2;
      5'd6:    gap_ld = LdClr;
      default: gap_ld = LdCmd;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = LdSetup;
    case (state_q)
      StPwrup: if (tmr_done) begin
        state_d  = StLoad;
        tmr_load = 1'b1;
        tmr_val  = LdSetup;
      end
      StLoad: if (tmr_done) begin
        state_d  = StEnHi1;
        tmr_load = 1'b1;
        tmr_val  = LdEn;
      end
      StEnHi1: if (tmr_done) begin
        state_d  = StGap1;
        tmr_load = 1'b1;
        tmr_val  = LdNib;
      end
      StGap1: if (tmr_done) begin
        state_d  = StLoad2;
        tmr_load = 1'b1;
        tmr_val  = LdSetup;
      end
      StLoad2: if (tmr_done) begin
        state_d  = StEnHi2;
        tmr_load = 1'b1;
        tmr_val  = LdEn;
      end
      StEnHi2: if (tmr_done) begin
        state_d  = StWait;
        tmr_load = 1'b1;
        tmr_val  = gap_ld;
      end
      StWait: if (tmr_done) begin
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d    = idx_q + 5'd1;
          state_d  = StLoad;
          tmr_load = 1'b1;
          tmr_val  = LdSetup;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StPwrup;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StPwrup;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Bus and RS are pure decodes of state/index, so they only move on state changes away from EN edges.
  always_comb begin
    en     = (state_q == StEnHi1) || (state_q == StEnHi2);
    rs     = (state_q != StPwrup) && (idx_q >= FirstData);
    uo_out = '0;
    case (state_q)
      StPwrup:                 uo_out = '0;
      StLoad, StEnHi1, StGap1: uo_out = {cur_byte[7:4], cur_byte[7:4]};
      default:                 uo_out = cur_byte;
    endcase
  end

  assign uio_out = {5'b0, en, 1'b0, rs};
  assign uio_oe  = {7'b0, en};

endmodule

// File: tb/tb_lcd_hd44780_init_writer.sv
// Directed bench for the HD44780 writer, run with shortened microsecond delays at the real clock rate.
module tb_lcd_hd44780_init_writer;

  localparam int CYC_US  = 50;
  localparam int PWRUP   = 150 * CYC_US;
  localparam int INIT1   = 50 * CYC_US;
  localparam int INIT2   = 20 * CYC_US;
  localparam int CLR     = 30 * CYC_US;
  localparam int CMD     = 5 * CYC_US;
  localparam int NIB     = 1 * CYC_US;
  localparam int EN_CYC  = 12;
  localparam int BUDGET  = 30000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_bytes [19] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h08, 8'h01, 8'h06, 8'h0C,
                                 8'h54, 8'h48, 8'h45, 8'h20, 8'h47, 8'h41, 8'h4D, 8'h45, 8'h20,
                                 8'h20};

  lcd_hd44780_init_writer #(
    .CLK_HZ     (50_000_000),
    .T_PWRUP_US (150),
    .T_CMD_US   (5),
    .T_INIT1_US (50),
    .T_INIT2_US (20),
    .T_CLR_US   (30),
    .T_NIB_US   (1),
    .EN_CYC     (12)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #10 clk = ~clk;

  // Ignored inputs get random values throughout.
  initial forever begin
    @(posedge clk);
    #2;
    ena    = 1'($urandom_range(0, 1));
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
  end

  function automatic int gap_cycles(input int i);
    case (i)
      0:       return INIT1;
      1:       return INIT2;
      6:       return CLR;
      default: return CMD;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (uo_out !== 8'h00) begin
      n_bad++; $display("FAIL reset_uo_out: got %h want 00", uo_out);
    end
    n_cmp++;
    if (uio_out !== 8'h00) begin
      n_bad++; $display("FAIL reset_uio_out: got %h want 00", uio_out);
    end
    n_cmp++;
    if (uio_oe !== 8'h00) begin
      n_bad++; $display("FAIL reset_uio_oe: got %h want 00", uio_oe);
    end
    rst_n = 1'b0;
  endtask

  // Must be entered at the negedge where reset was released.
  task automatic test_sequence(input string tag);
    int cyc = 0, nfall = 0, rise_t = 0, last_fall = 0, b = 0;
    int last_edge = -100, last_chg = -100, first_rise = -1;
    int width_bad = 0, setup_bad = 0, hold_bad = 0, copy_bad = 0, clash_bad = 0;
    logic en, en_p;
    logic [8:0] bus, bus_p;
    en_p  = uio_oe[0];
    bus_p = {uo_out, uio_out[0]};
    while (nfall < 38 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      en  = uio_oe[0];
      bus = {uo_out, uio_out[0]};
      if (en !== uio_out[2]) copy_bad++;
      if (bus !== bus_p) begin
        if (en !== en_p) clash_bad++;
        if (cyc - last_edge < 2) hold_bad++;
        last_chg = cyc;
      end
      if (en && !en_p) begin
        if (first_rise < 0) first_rise = cyc;
        if (cyc - last_chg < 2) setup_bad++;
        rise_t    = cyc;
        last_edge = cyc;
      end else if (!en && en_p) begin
        nfall++;
        last_edge = cyc;
        if (cyc - rise_t < EN_CYC) width_bad++;
        b = (nfall - 1) / 2;
        if (nfall % 2 == 1) begin
          if (nfall == 1) begin
            n_cmp++;
            if (uo_out[3:0] !== 4'h3) begin
              n_bad++; $display("FAIL %s first_nibble: got %h want 3", tag, uo_out[3:0]);
            end
            n_cmp++;
            if (uio_out[0] !== 1'b0) begin
              n_bad++; $display("FAIL %s first_rs: got %b want 0", tag, uio_out[0]);
            end
          end else begin
            n_cmp++;
            if (cyc - last_fall != gap_cycles(b - 1) + 2 + EN_CYC) begin
              n_bad++;
              $display("FAIL %s byte_gap%0d: got %0d cycles want %0d", tag, b - 1,
                       cyc - last_fall, gap_cycles(b - 1) + 2 + EN_CYC);
            end
          end
        end else begin
          n_cmp++;
          if (uo_out !== exp_bytes[b]) begin
            n_bad++; $display("FAIL %s byte%0d: got %h want %h", tag, b, uo_out, exp_bytes[b]);
          end
          n_cmp++;
          if (uio_out[0] !== (b >= 9)) begin
            n_bad++; $display("FAIL %s rs%0d: got %b want %b", tag, b, uio_out[0], b >= 9);
          end
          n_cmp++;
          if (cyc - last_fall != NIB + 2 + EN_CYC) begin
            n_bad++;
            $display("FAIL %s nibble_gap%0d: got %0d cycles want %0d", tag, b,
                     cyc - last_fall, NIB + 2 + EN_CYC);
          end
        end
        last_fall = cyc;
      end
      en_p  = en;
      bus_p = bus;
    end
    n_cmp++;
    if (nfall != 38) begin
      n_bad++; $display("FAIL %s pulse_count: got %0d falls want 38 (budget)", tag, nfall);
    end
    n_cmp++;
    if (first_rise < PWRUP || first_rise > PWRUP + 10) begin
      n_bad++; $display("FAIL %s pwrup_wait: first EN rise at %0d cycles want %0d..%0d", tag,
                        first_rise, PWRUP, PWRUP + 10);
    end
    n_cmp++;
    if (width_bad != 0) begin
      n_bad++; $display("FAIL %s en_width: got %0d short pulses want 0", tag, width_bad);
    end
    n_cmp++;
    if (setup_bad != 0 || hold_bad != 0 || clash_bad != 0) begin
      n_bad++; $display("FAIL %s bus_stability: got setup %0d hold %0d clash %0d want 0", tag,
                        setup_bad, hold_bad, clash_bad);
    end
    n_cmp++;
    if (copy_bad != 0) begin
      n_bad++; $display("FAIL %s en_copy: got %0d differing cycles want 0", tag, copy_bad);
    end
  endtask

  task automatic test_idle_after_done();
    int rises = 0, changes = 0;
    logic en_p;
    logic [23:0] snap;
    en_p = uio_oe[0];
    snap = {uo_out, uio_out, uio_oe};
    repeat (100 * CYC_US) begin
      @(negedge clk);
      if (uio_oe[0] && !en_p) rises++;
      en_p = uio_oe[0];
      if ({uo_out, uio_out, uio_oe} !== snap) changes++;
    end
    n_cmp++;
    if (rises != 0) begin
      n_bad++; $display("FAIL idle_pulses: got %0d want 0", rises);
    end
    n_cmp++;
    if (changes != 0) begin
      n_bad++; $display("FAIL idle_stable: got %0d changed cycles want 0", changes);
    end
    n_cmp++;
    if (uo_out !== 8'h20 || uio_out !== 8'h01) begin
      n_bad++; $display("FAIL idle_hold: got uo %h uio %h want 20 01", uo_out, uio_out);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0, nfall = 0;
    logic en_p;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    en_p  = 1'b0;
    while (!(nfall >= 24 && uio_oe[0]) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (!uio_oe[0] && en_p) nfall++;
      en_p = uio_oe[0];
    end
    n_cmp++;
    if (nfall < 24 || !uio_oe[0]) begin
      n_bad++; $display("FAIL mid_reach: got %0d falls en %b want 24 en 1", nfall, uio_oe[0]);
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (uo_out !== 8'h00) begin
      n_bad++; $display("FAIL mid_async_uo_out: got %h want 00", uo_out);
    end
    n_cmp++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      n_bad++; $display("FAIL mid_async_uio: got %h/%h want 00/00", uio_out, uio_oe);
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence("first");
    test_idle_after_done();
    test_reset_mid();
    test_sequence("replay");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
